// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the execute-stage ALU and the ALU decoder.
//   - alu_op_t and the ALUControl op codes (ADD..SRA)
//   - state_t: FSM encoding of alu_exec_stage
//   - is_shift(): true for the three shift op codes
package alu_pkg;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ADD = 3'b000;
  localparam alu_op_t SUB = 3'b001;
  localparam alu_op_t AND = 3'b010;
  localparam alu_op_t OR  = 3'b011;
  localparam alu_op_t SLL = 3'b100;
  localparam alu_op_t SLT = 3'b101;
  localparam alu_op_t SRL = 3'b110;
  localparam alu_op_t SRA = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(alu_op_t op);
    return (op == SLL) || (op == SRL) || (op == SRA);
  endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// alu_exec_stage_if: request/response bundle of the execute-stage ALU.
//   Request : in_valid, in_ready, alu_ctrl, src_a, src_b
//   Response: out_valid, out_ready, result, zero, busy
//   master = issuing core side, slave = alu_exec_stage.
interface alu_exec_stage_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  alu_op_t          alu_ctrl;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, alu_ctrl, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, alu_ctrl, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/alu_comb.sv
// alu_comb: purely combinational add/sub/and/or/slt datapath.
//   op : ALUControl code (shift codes produce 0; shifts are handled elsewhere)
//   a,b: operands
//   y  : result (add/sub wrap; slt is signed, result is 0 or 1)
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;

  assign a_s = a;
  assign b_s = b;

  always_comb begin
    y = '0;
    case (op)
      ADD:     y = a + b;
      SUB:     y = a - b;
      AND:     y = a & b;
      OR:      y = a | b;
      SLT:     y = (a_s < b_s) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute-stage ALU with registered result and zero flag.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : alu_exec_stage_if.slave (in_valid/in_ready request with
//              alu_ctrl/src_a/src_b; out_valid/out_ready response with
//              result/zero; busy is high while a shift is iterating)
// Shifts iterate one bit per cycle unless ALU_FAST_SHIFT_EN is defined, in
// which case a barrel shifter makes every op single-cycle and busy stays 0.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic        clk,
  input  logic        rst,
  alu_exec_stage_if.slave bus
);
  state_t           state_p0, state_p1;
  logic [WIDTH-1:0] result_p0, result_p1;
  logic             zero_p1;
  logic [WIDTH-1:0] alu_y;
  logic [SHW-1:0]   shamt;
  logic             accept;

`ifndef ALU_FAST_SHIFT_EN
  logic [SHW-1:0]   cnt_p0, cnt_p1;
  alu_op_t          sop_p0, sop_p1;

  function automatic logic [WIDTH-1:0] shift1(alu_op_t op, logic [WIDTH-1:0] v);
    case (op)
      SLL:     return {v[WIDTH-2:0], 1'b0};
      SRA:     return {v[WIDTH-1], v[WIDTH-1:1]};
      default: return {1'b0, v[WIDTH-1:1]};
    endcase
  endfunction
`else
  function automatic logic [WIDTH-1:0] barrel(alu_op_t op, logic [WIDTH-1:0] v,
                                             logic [SHW-1:0] sh);
    logic signed [WIDTH-1:0] vs;
    vs = v;
    case (op)
      SLL:     return v << sh;
      SRA:     return vs >>> sh;
      default: return v >> sh;
    endcase
  endfunction
`endif

  alu_comb #(.WIDTH(WIDTH)) u_alu_comb (
    .op (bus.alu_ctrl),
    .a  (bus.src_a),
    .b  (bus.src_b),
    .y  (alu_y)
  );

  assign shamt        = bus.src_b[SHW-1:0];
  // DONE with out_ready lets a new op enter on the same edge the result leaves.
  assign bus.in_ready = (state_p1 == ST_IDLE) || ((state_p1 == ST_DONE) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    state_p0  = state_p1;
    result_p0 = result_p1;
`ifndef ALU_FAST_SHIFT_EN
    cnt_p0    = cnt_p1;
    sop_p0    = sop_p1;
`endif
    case (state_p1)
`ifndef ALU_FAST_SHIFT_EN
      ST_SHIFT: begin
        result_p0 = shift1(sop_p1, result_p1);
        cnt_p0    = cnt_p1 - SHW'(1);
        if (cnt_p1 == SHW'(1)) state_p0 = ST_DONE;
      end
`endif
      ST_DONE:  if (bus.out_ready) state_p0 = ST_IDLE;
      default:  ;
    endcase

    if (accept) begin
      state_p0 = ST_DONE;
      if (is_shift(bus.alu_ctrl)) begin
`ifdef ALU_FAST_SHIFT_EN
        result_p0 = barrel(bus.alu_ctrl, bus.src_a, shamt);
`else
        if (shamt == '0) begin
          result_p0 = bus.src_a;
        end else begin
          // First step happens on the accept edge, so shamt-1 steps remain.
          result_p0 = shift1(bus.alu_ctrl, bus.src_a);
          cnt_p0    = shamt - SHW'(1);
          sop_p0    = bus.alu_ctrl;
          if (shamt != SHW'(1)) state_p0 = ST_SHIFT;
        end
`endif
      end else begin
        result_p0 = alu_y;
      end
    end
  end

  // ---- p0 -> p1: state, working/result register and zero flag ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1  <= ST_IDLE;
      result_p1 <= '0;
      zero_p1   <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      cnt_p1    <= '0;
      sop_p1    <= ADD;
`endif
    end else begin
      state_p1  <= state_p0;
      result_p1 <= result_p0;
      zero_p1   <= (result_p0 == '0);
`ifndef ALU_FAST_SHIFT_EN
      cnt_p1    <= cnt_p0;
      sop_p1    <= sop_p0;
`endif
    end
  end

  assign bus.out_valid = (state_p1 == ST_DONE);
  assign bus.result    = result_p1;
  assign bus.zero      = zero_p1;
`ifdef ALU_FAST_SHIFT_EN
  assign bus.busy      = 1'b0;
`else
  assign bus.busy      = (state_p1 == ST_SHIFT);
`endif
endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_exec_stage_if #(.WIDTH(32)) bus();

  alu_exec_stage #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: what an ALU computes, straight from the op definitions.
  function automatic logic [31:0] ref_result(alu_op_t op, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      ADD: return a + b;
      SUB: return a - b;
      AND: return a & b;
      OR:  return a | b;
      SLT: return (sa < sb) ? 32'd1 : 32'd0;
      SLL: return a << b[4:0];
      SRL: return a >> b[4:0];
      default: return sa >>> b[4:0];
    endcase
  endfunction

  function automatic int ref_lat(alu_op_t op, logic [31:0] b);
    if (!FAST && (op == SLL || op == SRL || op == SRA) && b[4:0] != 5'd0)
      return int'(b[4:0]);
    return 1;
  endfunction

  // Issue one op from idle with out_ready=1, then measure latency and result.
  task automatic run_op(string tag, alu_op_t op, logic [31:0] a, logic [31:0] b);
    logic [31:0] exp_r;
    int exp_l, lat, busy_cnt;
    exp_r = ref_result(op, a, b);
    exp_l = ref_lat(op, b);
    bus.in_valid = 1'b1;
    bus.alu_ctrl = op;
    bus.src_a    = a;
    bus.src_b    = b;
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
    // Scramble inputs: operands must have been latched at accept.
    bus.in_valid = 1'b0;
    bus.alu_ctrl = alu_op_t'($urandom);
    bus.src_a    = $urandom;
    bus.src_b    = $urandom;
    lat = 1;
    busy_cnt = 0;
    while (!bus.out_valid && lat < 64) begin
      if (bus.busy) busy_cnt++;
      tick();
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_l));
    check({tag, ".result"}, bus.result, exp_r);
    check({tag, ".zero"}, 32'(bus.zero), 32'(exp_r == 32'd0));
    check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(exp_l - 1));
    tick();
    check({tag, ".drain"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ea;
    logic [31:0] eb;
    int vcnt;

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.alu_ctrl  = ADD;
    bus.src_a     = '0;
    bus.src_b     = '0;
    tick();
    tick();
    check("reset.out_valid", 32'(bus.out_valid), 32'd0);
    check("reset.result", bus.result, 32'd0);
    check("reset.zero", 32'(bus.zero), 32'd0);
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Directed single-cycle ops and shifts
    run_op("add_wrap", ADD, 32'hFFFF_FFFF, 32'd1);
    check("add_wrap.literal", bus.result, 32'd0);
    run_op("sub", SUB, 32'd5, 32'd7);
    check("sub.literal", bus.result, 32'hFFFF_FFFE);
    run_op("slt_neg", SLT, 32'hFFFF_FFFF, 32'd1);
    check("slt_neg.literal", bus.result, 32'd1);
    run_op("slt_pos", SLT, 32'd1, 32'hFFFF_FFFF);
    check("slt_pos.literal", bus.result, 32'd0);
    run_op("and", AND, 32'h0000_F0F0, 32'h0000_0FF0);
    check("and.literal", bus.result, 32'h0000_00F0);
    run_op("or", OR, 32'h0000_F0F0, 32'h0000_0FF0);
    check("or.literal", bus.result, 32'h0000_FFF0);
    run_op("sra4", SRA, 32'h8000_0000, 32'hFFFF_FFE4);
    check("sra4.literal", bus.result, 32'hF800_0000);
    run_op("srl4", SRL, 32'h8000_0000, 32'hFFFF_FFE4);
    check("srl4.literal", bus.result, 32'h0800_0000);
    run_op("sll0", SLL, 32'h1234_5678, 32'hFFFF_FFE0);
    check("sll0.literal", bus.result, 32'h1234_5678);
    run_op("sll31", SLL, 32'd1, 32'd31);
    check("sll31.literal", bus.result, 32'h8000_0000);
    run_op("sra1", SRA, 32'h8000_0001, 32'd1);

    // Backpressure: add 3+4 held while out_ready=0; next op waits then enters
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.alu_ctrl  = ADD;
    bus.src_a     = 32'd3;
    bus.src_b     = 32'd4;
    tick();
    bus.alu_ctrl  = SUB;
    bus.src_a     = 32'd10;
    bus.src_b     = 32'd4;
    for (int i = 0; i < 5; i++) begin
      check("bp.out_valid", 32'(bus.out_valid), 32'd1);
      check("bp.result_held", bus.result, 32'd7);
      check("bp.in_ready_low", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp.in_ready_release", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("bp.next_valid", 32'(bus.out_valid), 32'd1);
    check("bp.next_result", bus.result, 32'd6);
    tick();
    check("bp.drain", 32'(bus.out_valid), 32'd0);

    // Back-to-back stream of adds: one result per edge, in order
    bus.in_valid = 1'b1;
    bus.alu_ctrl = ADD;
    for (int i = 0; i < 4; i++) begin
      ea = $urandom;
      eb = $urandom;
      bus.src_a = ea;
      bus.src_b = eb;
      check("b2b.in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      check("b2b.out_valid", 32'(bus.out_valid), 32'd1);
      check("b2b.result", bus.result, ea + eb);
    end
    bus.in_valid = 1'b0;
    tick();
    check("b2b.drain", 32'(bus.out_valid), 32'd0);

`ifndef ALU_FAST_SHIFT_EN
    // Reset in the middle of a 20-step shift discards it
    bus.in_valid = 1'b1;
    bus.alu_ctrl = SLL;
    bus.src_a    = 32'd1;
    bus.src_b    = 32'd20;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("rstmid.busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid.out_valid", 32'(bus.out_valid), 32'd0);
    check("rstmid.result", bus.result, 32'd0);
    check("rstmid.in_ready", 32'(bus.in_ready), 32'd1);
    check("rstmid.busy", 32'(bus.busy), 32'd0);
    vcnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.out_valid) vcnt++;
      tick();
    end
    check("rstmid.no_result", 32'(vcnt), 32'd0);
`endif

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      run_op("rand", alu_op_t'($urandom_range(0, 7)), $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute-stage ALU; consumes the 3-bit ALUControl code from the ALU decoder plus two operands, and produces a registered result and Zero flag.
- Single-cycle ops complete in 1 cycle. Shifts run iteratively, 1 bit per cycle.
- Valid/ready handshakes on both sides let the core stall around multi-cycle shifts.

Parameters:
- WIDTH, 32, operand/result width; must be a power of 2, >= 8.
- SHW, $clog2(WIDTH), shift-amount width; src_b[SHW-1:0] is the shamt.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operation request
- in_ready  output  1  stage can accept request this cycle
- alu_ctrl  input  3  000 add, 001 sub, 010 and, 011 or, 100 sll, 101 slt, 110 srl, 111 sra
- src_a  input  WIDTH  operand A / shift source
- src_b  input  WIDTH  operand B / shamt in low SHW bits
- out_valid  output  1  result held valid
- out_ready  input  1  downstream accepts result
- result  output  WIDTH  registered result
- zero  output  1  registered (result == 0), used for beq
- busy  output  1  high in SHIFT state

Behaviour:
- Reset (synchronous, rst=1 at edge): state=IDLE, out_valid=0, result=0, zero=0, busy=0, shift counter=0. Overrides any operation in progress; a partial shift is discarded with no output.
- FSM states: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Accept = in_valid & in_ready.
- Accept, non-shift op, or shift with shamt==0: compute and register result, go to DONE (latency 1 edge).
- Accept, shift with shamt!=0: load src_a shifted by 1, cnt=shamt-1. If cnt==0 go to DONE, else go to SHIFT. Latency is shamt edges.
- SHIFT: each edge shifts the working register by 1 in the latched direction and decrements cnt. When cnt reaches 0, go to DONE. in_ready=0; in_valid is ignored.
- DONE: out_valid=1. result/zero are stable while out_ready=0.
  - out_ready & !accept: go to IDLE, out_valid=0.
  - out_ready & accept: back-to-back; the new op is processed as from IDLE in the same edge.
- Arithmetic:
  - add/sub wrap modulo 2^WIDTH; no carry/overflow outputs.
  - slt is signed two's complement: result = {0..., a<b}.
  - sll/srl fill zeros; sra replicates the latched MSB every step.
  - Only src_b[SHW-1:0] is used for shifts; upper bits are ignored.
- zero is computed from the value written to result, in the same edge.
- Operands and alu_ctrl are sampled only at accept; later input changes have no effect.

Optional Feature:
- Macro ALU_FAST_SHIFT_EN.
- Defined: shifts use a combinational barrel shifter. Every op has latency 1, the SHIFT state and counter are removed, and busy is tied to 0.
- Undefined: iterative shifting as specified above.
- Port list is identical either way.

Decomposition:
- Shared package alu_pkg:
  - ALU op localparams (ADD=3'b000, SUB=3'b001, AND=3'b010, OR=3'b011, SLL=3'b100, SLT=3'b101, SRL=3'b110, SRA=3'b111); the ALU decoder imports the same package.
  - FSM state encoding.
- One sub-module, alu_comb: combinational add/sub/and/or/slt datapath, reusable in other stages.
- Shift FSM and handshake logic stay in alu_exec_stage.

Test Plan:
- Reset mid-shift: sll a=1, shamt=20; assert rst at cycle 5 -> next cycle state IDLE, out_valid=0, result=0, in_ready=1, and no result ever emerges.
- Single-cycle ops: add 0xFFFFFFFF+1 -> result 0, zero=1 after 1 edge. sub 5-7 -> 0xFFFFFFFE. slt -1<1 -> 1. slt 1<-1 -> 0. and/or 0xF0F0,0x0FF0 -> 0x00F0 / 0xFFF0.
- Iterative shifts:
  - sra a=0x80000000, b=0xFFFFFFE4 (shamt 4) -> out_valid exactly 4 edges after accept, result 0xF8000000, busy high 3 cycles.
  - srl same inputs -> 0x08000000.
  - sll shamt=0 -> 1 edge, result=a.
- Backpressure: out_ready=0 for 5 cycles after add 3+4 -> result 7 held stable, in_ready=0; the new request is accepted in the same cycle out_ready rises.
- Back-to-back stream of 4 adds with out_ready=1, in_valid=1 -> one result per cycle, no bubbles, in order.
- ALU_FAST_SHIFT_EN build: sll 1 by 31 -> 0x80000000 after 1 edge, busy never asserted.
